// File: rtl/stream_demux_2.sv
// Two-way valid/ready packet demultiplexer with a one-beat register slot per output.
// The destination is chosen from select_i on a packet's first beat and held until its last beat.
module stream_demux_2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  select_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_last_o,
    output logic                  m0_valid_o,
    input  logic                  m0_ready_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_last_o,
    output logic                  m1_valid_o,
    input  logic                  m1_ready_i
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ROUTE = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic                  dest_q, dest_d;

    logic                  m0_valid_q, m0_valid_d;
    logic                  m0_last_q, m0_last_d;
    logic [DATA_WIDTH-1:0] m0_data_q, m0_data_d;
    logic                  m1_valid_q, m1_valid_d;
    logic                  m1_last_q, m1_last_d;
    logic [DATA_WIDTH-1:0] m1_data_q, m1_data_d;

    logic                  target_s;
    logic                  free0_s;
    logic                  free1_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  load0_s;
    logic                  load1_s;

    // Target selection and input handshake; only the target slot gates s_ready_o.
    always_comb begin
        free0_s = ~m0_valid_q | m0_ready_i;
        free1_s = ~m1_valid_q | m1_ready_i;
        if (state_q == ST_ROUTE) begin
            target_s = dest_q;
        end else begin
            target_s = select_i;
        end
        ready_s  = target_s ? free1_s : free0_s;
        accept_s = s_valid_i & ready_s;
        load0_s  = accept_s & ~target_s;
        load1_s  = accept_s & target_s;
    end

    // Packet FSM: a lock is only taken for multi-beat packets.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !s_last_i) begin
                    state_d = ST_ROUTE;
                    dest_d  = select_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUTE: begin
                if (accept_s && s_last_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ROUTE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dest_d  = 1'b0;
            end
        endcase
    end

    // Output slot 0: a load wins over a drain so a same-cycle drain+load keeps valid high.
    always_comb begin
        m0_valid_d = m0_valid_q;
        m0_last_d  = m0_last_q;
        m0_data_d  = m0_data_q;
        if (load0_s) begin
            m0_valid_d = 1'b1;
            m0_last_d  = s_last_i;
            m0_data_d  = s_data_i;
        end else if (m0_ready_i) begin
            m0_valid_d = 1'b0;
        end else begin
            m0_valid_d = m0_valid_q;
        end
    end

    // Output slot 1: same policy as slot 0.
    always_comb begin
        m1_valid_d = m1_valid_q;
        m1_last_d  = m1_last_q;
        m1_data_d  = m1_data_q;
        if (load1_s) begin
            m1_valid_d = 1'b1;
            m1_last_d  = s_last_i;
            m1_data_d  = s_data_i;
        end else if (m1_ready_i) begin
            m1_valid_d = 1'b0;
        end else begin
            m1_valid_d = m1_valid_q;
        end
    end

    // FSM and destination lock registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            dest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    // Slot registers; reset discards any beat in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m0_valid_q <= 1'b0;
            m0_last_q  <= 1'b0;
            m0_data_q  <= {DATA_WIDTH{1'b0}};
            m1_valid_q <= 1'b0;
            m1_last_q  <= 1'b0;
            m1_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            m0_valid_q <= m0_valid_d;
            m0_last_q  <= m0_last_d;
            m0_data_q  <= m0_data_d;
            m1_valid_q <= m1_valid_d;
            m1_last_q  <= m1_last_d;
            m1_data_q  <= m1_data_d;
        end
    end

    assign s_ready_o  = ready_s;
    assign m0_valid_o = m0_valid_q;
    assign m0_last_o  = m0_last_q;
    assign m0_data_o  = m0_data_q;
    assign m1_valid_o = m1_valid_q;
    assign m1_last_o  = m1_last_q;
    assign m1_data_o  = m1_data_q;

endmodule

// File: tb/tb_stream_demux_2.sv
// Randomised and directed bench for stream_demux_2 against a queue-based packet routing model.
module tb_stream_demux_2;
    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          select_i = 1'b0;
    logic [DW-1:0] s_data_i = '0;
    logic          s_last_i = 1'b0;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [DW-1:0] m0_data_o, m1_data_o;
    logic          m0_last_o, m0_valid_o, m0_ready_i = 1'b1;
    logic          m1_last_o, m1_valid_o, m1_ready_i = 1'b1;

    stream_demux_2 #(.DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .select_i(select_i),
        .s_data_i(s_data_i), .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m0_data_o(m0_data_o), .m0_last_o(m0_last_o), .m0_valid_o(m0_valid_o), .m0_ready_i(m0_ready_i),
        .m1_data_o(m1_data_o), .m1_last_o(m1_last_o), .m1_valid_o(m1_valid_o), .m1_ready_i(m1_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Model: beats waiting on each output (FIFO order), plus open-packet lock.
    logic [DW:0] q0[$];
    logic [DW:0] q1[$];
    bit          m_open = 1'b0;
    bit          m_dest = 1'b0;
    bit          last_acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs already driven by the caller; checks s_ready then outputs.
    task automatic tick();
        bit tgt, exp_rdy, dr0, dr1;
        #1;
        tgt     = m_open ? m_dest : select_i;
        exp_rdy = tgt ? (q1.size() == 0 || m1_ready_i) : (q0.size() == 0 || m0_ready_i);
        chk("s_ready", {31'd0, s_ready_o}, {31'd0, exp_rdy});
        last_acc = s_valid_i && exp_rdy;
        dr0 = (q0.size() > 0) && m0_ready_i;
        dr1 = (q1.size() > 0) && m1_ready_i;
        @(posedge clk_i);
        #1;
        if (dr0) void'(q0.pop_front());
        if (dr1) void'(q1.pop_front());
        if (last_acc) begin
            if (tgt) q1.push_back({s_last_i, s_data_i});
            else     q0.push_back({s_last_i, s_data_i});
            if (!m_open && !s_last_i) begin
                m_open = 1'b1;
                m_dest = tgt;
            end else if (m_open && s_last_i) begin
                m_open = 1'b0;
            end
        end
        chk("m0_valid", {31'd0, m0_valid_o}, {31'd0, q0.size() != 0});
        chk("m1_valid", {31'd0, m1_valid_o}, {31'd0, q1.size() != 0});
        if (q0.size() != 0) chk("m0_beat", {23'd0, m0_last_o, m0_data_o}, {23'd0, q0[0]});
        if (q1.size() != 0) chk("m1_beat", {23'd0, m1_last_o, m1_data_o}, {23'd0, q1[0]});
    endtask

    task automatic drive(input bit v, input bit sel, input logic [DW-1:0] d, input bit l);
        s_valid_i = v;
        select_i  = sel;
        s_data_i  = d;
        s_last_i  = l;
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_v0"}, {31'd0, m0_valid_o}, 32'd0);
        chk({name, "_v1"}, {31'd0, m1_valid_o}, 32'd0);
        chk({name, "_d0"}, {23'd0, m0_last_o, m0_data_o}, 32'd0);
        chk({name, "_d1"}, {23'd0, m1_last_o, m1_data_o}, 32'd0);
    endtask

    initial begin
        // 1: reset state
        #12;
        check_cleared("rst");
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_ready", {31'd0, s_ready_o}, 32'd1);
        tick();

        // 2: three-beat packet to m1, select toggled mid-packet
        drive(1'b1, 1'b1, 8'hA1, 1'b0); tick();
        chk("p2_b1", {22'd0, m1_valid_o, m1_last_o, m1_data_o}, {22'd0, 1'b1, 1'b0, 8'hA1});
        drive(1'b1, 1'b0, 8'hA2, 1'b0); tick();
        chk("p2_b2", {22'd0, m1_valid_o, m1_last_o, m1_data_o}, {22'd0, 1'b1, 1'b0, 8'hA2});
        drive(1'b1, 1'b0, 8'hA3, 1'b1); tick();
        chk("p2_b3", {22'd0, m1_valid_o, m1_last_o, m1_data_o}, {22'd0, 1'b1, 1'b1, 8'hA3});
        chk("p2_m0", {31'd0, m0_valid_o}, 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0); tick();

        // 3: back-to-back single-beat packets
        drive(1'b1, 1'b0, 8'h11, 1'b1); tick();
        chk("p3_m0", {23'd0, m0_last_o, m0_data_o}, {23'd0, 1'b1, 8'h11});
        drive(1'b1, 1'b1, 8'h22, 1'b1); tick();
        chk("p3_m1", {23'd0, m1_last_o, m1_data_o}, {23'd0, 1'b1, 8'h22});
        chk("p3_m0_gone", {31'd0, m0_valid_o}, 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0); tick();

        // 4: stalled output 0 backpressures the input
        m0_ready_i = 1'b0;
        drive(1'b1, 1'b0, 8'hB1, 1'b0); tick();
        drive(1'b1, 1'b1, 8'hB2, 1'b0);
        #1 chk("p4_stall_rdy", {31'd0, s_ready_o}, 32'd0);
        tick(); tick();
        chk("p4_hold", {22'd0, m0_valid_o, m0_last_o, m0_data_o}, {22'd0, 1'b1, 1'b0, 8'hB1});
        m0_ready_i = 1'b1;
        tick();
        chk("p4_b2", {23'd0, m0_last_o, m0_data_o}, {23'd0, 1'b0, 8'hB2});
        drive(1'b1, 1'b1, 8'hB3, 1'b1); tick();
        chk("p4_b3", {23'd0, m0_last_o, m0_data_o}, {23'd0, 1'b1, 8'hB3});
        drive(1'b0, 1'b0, 8'h00, 1'b0); tick();

        // 5: stalled m1 does not block traffic to m0
        m1_ready_i = 1'b0;
        drive(1'b1, 1'b1, 8'h55, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'hC0 + 8'(i), (i == 2));
            #1 chk("p5_rdy", {31'd0, s_ready_o}, 32'd1);
            tick();
            chk("p5_m0", {23'd0, m0_last_o, m0_data_o}, {23'd0, (i == 2), 8'hC0 + 8'(i)});
        end
        chk("p5_m1_hold", {23'd0, m1_last_o, m1_data_o}, {23'd0, 1'b1, 8'h55});
        m1_ready_i = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0); tick(); tick();

        // 6: reset in the middle of a four-beat packet
        drive(1'b1, 1'b1, 8'hD1, 1'b0); tick();
        drive(1'b1, 1'b1, 8'hD2, 1'b0); tick();
        #2 rst_n_i = 1'b0;
        #1 check_cleared("p6_rst");
        q0.delete(); q1.delete(); m_open = 1'b0; m_dest = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        drive(1'b1, 1'b0, 8'hE1, 1'b0); tick();
        chk("p6_m0", {22'd0, m0_valid_o, m0_last_o, m0_data_o}, {22'd0, 1'b1, 1'b0, 8'hE1});
        chk("p6_m1", {31'd0, m1_valid_o}, 32'd0);
        drive(1'b1, 1'b1, 8'hE2, 1'b1); tick();
        chk("p6_m0b", {23'd0, m0_last_o, m0_data_o}, {23'd0, 1'b1, 8'hE2});
        drive(1'b0, 1'b0, 8'h00, 1'b0); tick();

        // Random traffic; the producer holds an unaccepted beat unchanged.
        last_acc = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (!s_valid_i || last_acc) begin
                drive($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
                      $urandom_range(0, 2) == 0);
            end
            m0_ready_i = $urandom_range(0, 3) != 0;
            m1_ready_i = $urandom_range(0, 2) != 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
